// File: rtl/ifetch_unit.sv
// ifetch_unit: miniRV fetch stage owning the PC, single outstanding req/gnt/rvalid fetch, valid/ready to decode.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned commit targets into a sticky fault state.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        npc_we,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic        irom_gnt,
  input  logic        irom_rvalid,
  input  logic [31:0] irom_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_fault
);
  localparam logic [2:0] S_REQ  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
`ifdef IFETCH_MISALIGN_CHECK_EN
  localparam logic [2:0] S_FAULT = 3'd4;
`endif
  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic        fetch_done, commit, bad;
  assign fetch_done = (state_q == S_REQ && irom_gnt && irom_rvalid) || (state_q == S_WAIT && irom_rvalid);
  assign commit     = npc_we && ((state_q == S_HOLD && inst_ready) || state_q == S_EXEC);
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign bad = commit && (npc[1:0] != 2'b00);
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if (fetch_done) begin
      inst_d    = irom_rdata;
      inst_pc_d = pc_q;
      state_d   = S_HOLD;
    end else if (state_q == S_REQ && irom_gnt) begin
      state_d = S_WAIT;
    end
    if (state_q == S_HOLD && inst_ready) state_d = S_EXEC;
    if (commit) begin
      pc_d    = npc & ~32'h3;
      state_d = S_REQ;
    end
`ifdef IFETCH_MISALIGN_CHECK_EN
    if (bad) begin
      pc_d    = pc_q;
      state_d = S_FAULT;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk) fault_q <= !rst_n ? 1'b0 : (fault_q | bad);
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = bad;
`endif
  assign irom_req   = rst_n && state_q == S_REQ;
  assign irom_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_pc4   = inst_pc_q + 32'd4;
  assign inst_valid = state_q == S_HOLD;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios plus randomized memory/decode traffic against a transaction-level model.
module tb_ifetch_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        npc_we = 1'b0;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_gnt = 1'b0, irom_rvalid = 1'b0;
  logic [31:0] irom_rdata = 32'h0;
  logic [31:0] inst, inst_pc, inst_pc4;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        fetch_fault;
  int checks = 0, failures = 0;

  ifetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .npc(npc), .npc_we(npc_we),
    .irom_req(irom_req), .irom_addr(irom_addr), .irom_gnt(irom_gnt),
    .irom_rvalid(irom_rvalid), .irom_rdata(irom_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic idle_inputs();
    npc = 32'h0; npc_we = 1'b0; irom_gnt = 1'b0; irom_rvalid = 1'b0; irom_rdata = 32'h0; inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    irom_gnt = 1'b1; irom_rvalid = 1'b1;
    #1;
    checks++; if (irom_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%h exp=0", irom_req); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", inst_valid); end
    checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst); end
    checks++; if (inst_pc !== 32'h0 || inst_pc4 !== 32'h4) begin failures++; $display("FAIL rst_pc got=%h/%h exp=0/4", inst_pc, inst_pc4); end
    checks++; if (irom_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", irom_addr); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%h exp=0", fetch_fault); end
    idle_inputs();
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    do_reset();
    rst_n = 1'b1; irom_gnt = 1'b1; irom_rvalid = 1'b1; irom_rdata = 32'h0000_0093;
    #1;
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h0) begin failures++; $display("FAIL zw_req got=%h@%h exp=1@0", irom_req, irom_addr); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h93) begin failures++; $display("FAIL zw_inst got=%h/%h exp=1/00000093", inst_valid, inst); end
    checks++; if (inst_pc !== 32'h0 || inst_pc4 !== 32'h4) begin failures++; $display("FAIL zw_pc got=%h/%h exp=0/4", inst_pc, inst_pc4); end
    exp_pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      inst_ready = 1'b1; npc_we = 1'b1; npc = exp_pc + 32'd4;
      exp_pc = exp_pc + 32'd4;
      irom_rdata = rom(exp_pc);
      @(negedge clk);
      checks++; if (irom_req !== 1'b1 || irom_addr !== exp_pc || inst_valid !== 1'b0) begin failures++; $display("FAIL b2b_req got=%h@%h v=%h exp=1@%h v=0", irom_req, irom_addr, inst_valid, exp_pc); end
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || inst !== rom(exp_pc) || inst_pc !== exp_pc) begin failures++; $display("FAIL b2b_inst got=%h %h@%h exp=1 %h@%h", inst_valid, inst, inst_pc, rom(exp_pc), exp_pc); end
    end
    idle_inputs();
  endtask

  task automatic test_latency_stall();
    do_reset();
    rst_n = 1'b1; irom_gnt = 1'b1;
    #1;
    checks++; if (irom_req !== 1'b1) begin failures++; $display("FAIL lat_req got=%h exp=1", irom_req); end
    @(negedge clk);
    irom_gnt = 1'b0;
    checks++; if (irom_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL lat_wait got=%h/%h exp=0/0", irom_req, inst_valid); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0 || irom_req !== 1'b0) begin failures++; $display("FAIL lat_wait%0d got=%h/%h exp=0/0", k, inst_valid, irom_req); end
    end
    irom_rvalid = 1'b1; irom_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001 || inst_pc !== 32'h0) begin failures++; $display("FAIL lat_inst got=%h %h@%h exp=1 cafe0001@0", inst_valid, inst, inst_pc); end
    irom_rdata = 32'hBAD0_BAD0;
    npc_we = 1'b1; npc = 32'h100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      irom_rvalid = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001 || inst_pc !== 32'h0 || irom_addr !== 32'h0) begin failures++; $display("FAIL stall%0d got=%h %h@%h a=%h exp=1 cafe0001@0 a=0", k, inst_valid, inst, inst_pc, irom_addr); end
    end
    npc_we = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || irom_req !== 1'b0) begin failures++; $display("FAIL exec got=%h/%h exp=0/0", inst_valid, irom_req); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || irom_req !== 1'b0) begin failures++; $display("FAIL exec2 got=%h/%h exp=0/0", inst_valid, irom_req); end
    npc_we = 1'b1; npc = 32'h100;
    @(negedge clk);
    npc_we = 1'b0;
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h100) begin failures++; $display("FAIL commit got=%h@%h exp=1@00000100", irom_req, irom_addr); end
  endtask

  task automatic test_misalign();
    irom_gnt = 1'b1; irom_rvalid = 1'b1; irom_rdata = rom(32'h100);
    @(negedge clk);
    irom_gnt = 1'b0; irom_rvalid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin failures++; $display("FAIL mis_fetch got=%h@%h exp=1@00000100", inst_valid, inst_pc); end
    inst_ready = 1'b1; npc_we = 1'b1; npc = 32'h102;
    @(negedge clk);
    inst_ready = 1'b0; npc_we = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    checks++; if (fetch_fault !== 1'b1 || irom_req !== 1'b0 || inst_valid !== 1'b0 || irom_addr !== 32'h100) begin failures++; $display("FAIL fault got=%h r=%h v=%h a=%h exp=1 r=0 v=0 a=00000100", fetch_fault, irom_req, inst_valid, irom_addr); end
    irom_gnt = 1'b1; irom_rvalid = 1'b1; inst_ready = 1'b1; npc_we = 1'b1; npc = 32'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (fetch_fault !== 1'b1 || irom_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL fault_stuck%0d got=%h/%h/%h exp=1/0/0", k, fetch_fault, irom_req, inst_valid); end
    end
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (fetch_fault !== 1'b0 || irom_addr !== 32'h0 || irom_req !== 1'b1) begin failures++; $display("FAIL fault_clear got=%h a=%h r=%h exp=0 a=0 r=1", fetch_fault, irom_addr, irom_req); end
`else
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h100 || fetch_fault !== 1'b0) begin failures++; $display("FAIL mask got=%h@%h f=%h exp=1@00000100 f=0", irom_req, irom_addr, fetch_fault); end
`endif
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rst_n = 1'b1; irom_gnt = 1'b1;
    @(negedge clk);
    irom_gnt = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; irom_rvalid = 1'b1; irom_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h0) begin failures++; $display("FAIL mid_req got=%h@%h exp=1@0", irom_req, irom_addr); end
    @(negedge clk);
    irom_rvalid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || irom_req !== 1'b1 || inst !== 32'h0) begin failures++; $display("FAIL mid_late got=%h r=%h i=%h exp=0 r=1 i=0", inst_valid, irom_req, inst); end
  endtask

  task automatic test_wrap();
    do_reset();
    rst_n = 1'b1; irom_gnt = 1'b1; irom_rvalid = 1'b1; irom_rdata = 32'h1;
    @(negedge clk);
    irom_gnt = 1'b0; irom_rvalid = 1'b0; inst_ready = 1'b1; npc_we = 1'b1; npc = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%h@%h exp=1@fffffffc", irom_req, irom_addr); end
    inst_ready = 1'b0; npc_we = 1'b0; irom_gnt = 1'b1; irom_rvalid = 1'b1; irom_rdata = 32'hABC;
    @(negedge clk);
    checks++; if (inst_pc !== 32'hFFFF_FFFC || inst_pc4 !== 32'h0 || inst !== 32'hABC) begin failures++; $display("FAIL wrap got=%h/%h/%h exp=fffffffc/0/abc", inst_pc, inst_pc4, inst); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    bit need_req, holding, executing;
    int pend, lat, fetched;
    do_reset();
    rst_n = 1'b1;
    exp_pc = 32'h0; need_req = 1'b1; holding = 1'b0; executing = 1'b0; pend = -1; fetched = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      #1;
      checks++; if (irom_req !== need_req) begin failures++; $display("FAIL rnd_req c=%0d got=%h exp=%h", cyc, irom_req, need_req); end
      if (need_req) begin
        checks++; if (irom_addr !== exp_pc) begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", cyc, irom_addr, exp_pc); end
      end
      checks++; if (inst_valid !== holding) begin failures++; $display("FAIL rnd_valid c=%0d got=%h exp=%h", cyc, inst_valid, holding); end
      if (holding) begin
        checks++; if (inst !== rom(exp_pc) || inst_pc !== exp_pc || inst_pc4 !== exp_pc + 32'd4) begin failures++; $display("FAIL rnd_inst c=%0d got=%h@%h/%h exp=%h@%h", cyc, inst, inst_pc, inst_pc4, rom(exp_pc), exp_pc); end
      end
      irom_gnt = need_req ? 1'($urandom_range(0, 1)) : 1'b0;
      irom_rvalid = 1'b0; irom_rdata = $urandom;
      if (irom_gnt) begin
        lat = $urandom_range(0, 3);
        if (lat == 0) begin irom_rvalid = 1'b1; irom_rdata = rom(exp_pc); end
        else pend = lat;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin irom_rvalid = 1'b1; irom_rdata = rom(exp_pc); pend = -1; end
      end
      inst_ready = 1'($urandom_range(0, 1));
      npc_we = 1'($urandom_range(0, 1));
`ifdef IFETCH_MISALIGN_CHECK_EN
      npc = $urandom & ~32'h3;
`else
      npc = $urandom;
`endif
      if (irom_gnt) need_req = 1'b0;
      if (holding && inst_ready) begin
        holding = 1'b0;
        if (npc_we) begin exp_pc = npc & ~32'h3; need_req = 1'b1; end
        else executing = 1'b1;
      end else if (executing && npc_we) begin
        executing = 1'b0; exp_pc = npc & ~32'h3; need_req = 1'b1;
      end
      if (irom_rvalid) begin holding = 1'b1; fetched++; end
      @(negedge clk);
    end
    checks++; if (fetched < 20) begin failures++; $display("FAIL rnd_progress got=%0d exp>=20", fetched); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency_stall();
    test_misalign();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage of the miniRV core; sits directly downstream of the next-PC generator.
- Owns the architectural PC register and loads it from the next-PC value when the current instruction commits.
- Fetches from instruction memory over a req/gnt/rvalid handshake, one fetch outstanding at a time.
- Presents instruction plus its PC and PC+4 to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; must be word-aligned.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- npc  in  32  next PC from the next-PC generator
- npc_we  in  1  commit strobe: current instruction retired; load npc into PC
- irom_req  out  1  fetch request
- irom_addr  out  32  fetch address (= PC)
- irom_gnt  in  1  memory accepted request
- irom_rvalid  in  1  read data valid
- irom_rdata  in  32  instruction word
- inst  out  32  fetched instruction
- inst_pc  out  32  PC of inst
- inst_pc4  out  32  inst_pc + 4, modulo 2^32
- inst_valid  out  1  inst/inst_pc/inst_pc4 valid
- inst_ready  in  1  decode accepts instruction
- fetch_fault  out  1  misaligned-target fault, sticky (feature only)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a clk edge) sets:
  - pc = RESET_PC; state = S_REQ
  - inst = 0; inst_pc = RESET_PC; inst_valid = 0; fetch_fault = 0
  - irom_req is forced to 0 combinationally while rst_n=0.
- irom_addr = pc at all times. inst_pc4 = inst_pc + 4, combinational, wraps 32'hFFFF_FFFC -> 0.
- S_REQ:
  - irom_req = 1; address stays stable until gnt.
  - gnt=1, rvalid=0 -> S_WAIT.
  - gnt=1 and rvalid=1 in the same cycle (zero-latency memory): latch inst = irom_rdata, inst_pc = pc, then go to S_HOLD.
- S_WAIT:
  - irom_req = 0.
  - rvalid=1 -> latch inst = irom_rdata, inst_pc = pc, then go to S_HOLD.
  - Arbitrary wait length.
- S_HOLD:
  - inst_valid = 1; inst, inst_pc and inst_pc4 are held stable until inst_ready=1.
  - inst_ready=1, npc_we=0 -> S_EXEC.
  - inst_ready=1 and npc_we=1 in the same cycle (single-cycle execute): pc <= npc, go to S_REQ. The next request is issued the following cycle.
- S_EXEC:
  - inst_valid = 0.
  - npc_we=1 -> pc <= npc, go to S_REQ.
- npc_we is ignored in S_REQ and S_WAIT, and in S_HOLD when inst_ready=0.
- rvalid is ignored outside S_WAIT and outside the S_REQ gnt cycle.
- irom_rdata is sampled only on the accepting rvalid.
- Latency:
  - Zero-wait memory gives inst_valid 1 cycle after irom_req rises.
  - Back-to-back throughput is 1 instruction per 2 cycles (REQ, HOLD with same-cycle commit).
- Alignment (feature off): pc loads {npc[31:2], 2'b00}.
- Reset mid-operation: an outstanding fetch is abandoned, and a late rvalid after reset is ignored, since the unit is in S_REQ awaiting gnt.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHECK_EN.
- Defined:
  - On a commit with npc[1:0] != 2'b00, pc is not updated and fetch_fault is set to 1 (sticky).
  - State goes to S_FAULT: irom_req = 0, inst_valid = 0, all inputs ignored.
  - Only reset exits S_FAULT.
- Undefined: S_FAULT is absent, fetch_fault is tied to 0, and low bits are masked as described above.

Test Plan:
- Reset release, RESET_PC=0, memory with gnt=1 and rvalid=1 in the same cycle returning 32'h0000_0093:
  - Cycle 1 after release: irom_req=1, irom_addr=0.
  - Cycle 2: inst_valid=1, inst=32'h0000_0093, inst_pc=0, inst_pc4=4.
- inst_ready=1 with npc_we=1 and npc=32'h0000_0004 -> next cycle irom_req=1, irom_addr=32'h4; sustained rate of one instruction per 2 cycles.
- Memory latency of 3 cycles after gnt:
  - irom_req drops after gnt; inst_valid stays 0 until the cycle after rvalid.
  - A spurious rvalid in S_HOLD does not change inst.
- Decode stall: inst_ready=0 for 5 cycles -> inst, inst_pc and inst_valid are stable.
- Decoupled commit: npc_we=1 with npc=32'h0000_0100 while in S_HOLD and inst_ready=0 -> ignored. Then inst_ready=1, and npc_we=1 two cycles later in S_EXEC -> irom_addr=32'h100.
- Misaligned npc=32'h0000_0102:
  - Macro undefined: irom_addr=32'h100.
  - Macro defined: fetch_fault=1, irom_req stays 0; after rst_n pulse low then high, fetch_fault=0 and irom_addr=RESET_PC.
